// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/exec/store/writeback instruction sequencer
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr_count,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_STORE = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // Watchdog only needs to count 0..TIMEOUT-1; the last value is the final allowed wait.
  localparam int                WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam bit                WD_EN   = (TIMEOUT != 0);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                br_taken_q, br_taken_d;
  logic [ADDR_W-1:0]   br_target_q, br_target_d;
  logic [ADDR_W-1:0]   st_addr_q, st_addr_d;
  logic [DATA_W-1:0]   st_data_q, st_data_d;
  logic [31:0]         count_q, count_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  // State and datapath registers; reset forces BOOT so requests drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      st_addr_q   <= '0;
      st_data_q   <= '0;
      count_q     <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
    end
  end

  // Next-state, memory handshake, watchdog and writeback logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = 1'b0;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    st_addr_d   = st_addr_q;
    st_data_d   = st_data_q;
    count_d     = count_q;
    wd_d        = wd_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = '0;
    case (state_q)
      S_BOOT: begin
        wd_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          instr_d = mem_rdata;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          br_taken_d  = branch_taken;
          br_target_d = branch_target;
          if (store_req) begin
            st_addr_d = store_addr;
            st_data_d = store_data;
            wd_d      = '0;
            state_d   = S_STORE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = st_addr_q;
        mem_wdata = st_data_q;
        if (mem_ready) begin
          state_d = S_WB;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      S_WB: begin
        pc_d    = br_taken_q ? br_target_q : (pc_q + PC_INC);
        count_d = count_q + 32'd1;
        wd_d    = '0;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign fault       = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        store_req;
  logic [31:0] store_addr;
  logic [31:0] store_data;

  logic        a_mem_req, a_mem_we, a_instr_valid, a_fault;
  logic [31:0] a_mem_addr, a_mem_wdata, a_instr, a_pc, a_instr_count;
  logic        b_mem_req, b_mem_we, b_instr_valid, b_fault;
  logic [7:0]  b_mem_addr, b_pc;
  logic [31:0] b_mem_wdata, b_instr, b_instr_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] pc_a;
  logic [7:0]  pc_b;
  logic [31:0] cnt;

  localparam logic [31:0] RPC_A = 32'h0;
  localparam logic [7:0]  RPC_B = 8'hFD;

  fetch_sequencer #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RPC_A), .PC_STEP(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(a_instr), .instr_valid(a_instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .pc(a_pc), .instr_count(a_instr_count), .fault(a_fault)
  );

  fetch_sequencer #(.ADDR_W(8), .DATA_W(32), .RESET_PC(RPC_B), .PC_STEP(1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(b_instr), .instr_valid(b_instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
    .store_req(store_req), .store_addr(store_addr[7:0]), .store_data(store_data),
    .pc(b_pc), .instr_count(b_instr_count), .fault(b_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic req, input logic we,
                           input logic [31:0] addr_a, input logic [7:0] addr_b,
                           input logic [31:0] wd, input logic iv);
    chk({tag, "_req_a"}, a_mem_req, req);
    chk({tag, "_req_b"}, b_mem_req, req);
    chk({tag, "_we_a"}, a_mem_we, we);
    chk({tag, "_we_b"}, b_mem_we, we);
    chk({tag, "_addr_a"}, a_mem_addr, addr_a);
    chk({tag, "_addr_b"}, b_mem_addr, addr_b);
    chk({tag, "_wdata_a"}, a_mem_wdata, wd);
    chk({tag, "_wdata_b"}, b_mem_wdata, wd);
    chk({tag, "_ivalid_a"}, a_instr_valid, iv);
    chk({tag, "_ivalid_b"}, b_instr_valid, iv);
    chk({tag, "_pc_a"}, a_pc, pc_a);
    chk({tag, "_pc_b"}, b_pc, pc_b);
    chk({tag, "_count_a"}, a_instr_count, cnt);
    chk({tag, "_count_b"}, b_instr_count, cnt);
    chk({tag, "_fault_a"}, a_fault, 1'b0);
    chk({tag, "_fault_b"}, b_fault, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_a"}, a_mem_req, 1'b0);
    chk({tag, "_req_b"}, b_mem_req, 1'b0);
    chk({tag, "_we_a"}, a_mem_we, 1'b0);
    chk({tag, "_we_b"}, b_mem_we, 1'b0);
    chk({tag, "_addr_a"}, a_mem_addr, RPC_A);
    chk({tag, "_addr_b"}, b_mem_addr, RPC_B);
    chk({tag, "_wdata_a"}, a_mem_wdata, 32'h0);
    chk({tag, "_instr_a"}, a_instr, 32'h0);
    chk({tag, "_instr_b"}, b_instr, 32'h0);
    chk({tag, "_ivalid_a"}, a_instr_valid, 1'b0);
    chk({tag, "_pc_a"}, a_pc, RPC_A);
    chk({tag, "_pc_b"}, b_pc, RPC_B);
    chk({tag, "_count_a"}, a_instr_count, 32'h0);
    chk({tag, "_count_b"}, b_instr_count, 32'h0);
    chk({tag, "_fault_a"}, a_fault, 1'b0);
    chk({tag, "_fault_b"}, b_fault, 1'b0);
  endtask

  task automatic quiet_inputs();
    mem_ready = 1'b0; mem_rdata = '0; exec_done = 1'b0; branch_taken = 1'b0;
    branch_target = '0; store_req = 1'b0; store_addr = '0; store_data = '0;
  endtask

  task automatic noise_inputs();
    branch_taken = 1'($urandom); branch_target = $urandom;
    store_req = 1'($urandom); store_addr = $urandom; store_data = $urandom;
  endtask

  // Assert reset, check the reset image, release just after a posedge so a full BOOT
  // cycle follows; returns at the negedge of the first FETCH cycle.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    quiet_inputs();
    repeat (2) @(negedge clk);
    check_reset_state(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pc_a = RPC_A; pc_b = RPC_B; cnt = 32'h0;
    @(negedge clk);
    check_bus({tag, "_boot"}, 1'b0, 1'b0, pc_a, pc_b, 32'h0, 1'b0);
    mem_ready = 1'b1; exec_done = 1'b1;
    @(negedge clk);
  endtask

  // One whole instruction from the negedge of its first FETCH cycle to the negedge of
  // the next FETCH; every intermediate cycle is checked so the latency is pinned too.
  task automatic run_instr(input int fw, input int ew, input int sw, input logic br,
                           input logic [31:0] tgt, input logic st,
                           input logic [31:0] sa, input logic [31:0] sd);
    logic [31:0] rd;
    rd = $urandom;
    for (int i = 0; i <= fw; i++) begin
      check_bus("fetch", 1'b1, 1'b0, pc_a, pc_b, 32'h0, 1'b0);
      mem_ready = (i == fw); mem_rdata = rd; exec_done = 1'($urandom);
      noise_inputs();
      @(negedge clk);
    end
    for (int i = 0; i <= ew; i++) begin
      check_bus("exec", 1'b0, 1'b0, pc_a, pc_b, 32'h0, (i == 0));
      if (i == 0) begin
        chk("instr_a", a_instr, rd);
        chk("instr_b", b_instr, rd);
      end
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      noise_inputs();
      exec_done = (i == ew);
      if (i == ew) begin
        branch_taken = br; branch_target = tgt;
        store_req = st; store_addr = sa; store_data = sd;
      end
      @(negedge clk);
    end
    if (st) begin
      for (int i = 0; i <= sw; i++) begin
        check_bus("store", 1'b1, 1'b1, sa, sa[7:0], sd, 1'b0);
        mem_ready = (i == sw); exec_done = 1'($urandom);
        noise_inputs();
        @(negedge clk);
      end
    end
    check_bus("wb", 1'b0, 1'b0, pc_a, pc_b, 32'h0, 1'b0);
    mem_ready = 1'($urandom); exec_done = 1'($urandom);
    noise_inputs();
    @(negedge clk);
    pc_a = br ? tgt : pc_a + 32'd1;
    pc_b = br ? tgt[7:0] : pc_b + 8'd1;
    cnt  = cnt + 32'd1;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    pc_a = RPC_A; pc_b = RPC_B; cnt = 32'h0;

    do_reset("reset0");

    // Zero-wait straight-line code; pc_b walks FD, FE, FF and wraps to 00.
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("count_after_3", a_instr_count, 32'd3);
    chk("pc_b_wrap", b_pc, 8'h00);

    // Fetch stalled three cycles, then ready on the last allowed cycle.
    run_instr(3, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    run_instr(0, 2, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("pc_before_branch", a_pc, 32'h5);

    // Taken branch from 0x5 to 0x100.
    run_instr(0, 0, 0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    chk("pc_after_branch", a_pc, 32'h100);
    chk("addr_after_branch", a_mem_addr, 32'h100);

    // Store, then branch back onto the same pc.
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF);
    chk("pc_after_store", a_pc, 32'h101);
    run_instr(1, 1, 2, 1'b1, pc_a, 1'b1, 32'h80, 32'h12345678);
    chk("pc_self_branch", a_pc, 32'h101);

    // Randomized instruction mix.
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                ($urandom_range(9, 0) < 3), $urandom, ($urandom_range(9, 0) < 3),
                $urandom, $urandom);
    end

    // Watchdog: four request cycles without ready lead to a sticky HALT.
    for (int i = 0; i < 4; i++) begin
      check_bus("timeout_wait", 1'b1, 1'b0, pc_a, pc_b, 32'h0, 1'b0);
      mem_ready = 1'b0; exec_done = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("halt_fault_a", a_fault, 1'b1);
      chk("halt_fault_b", b_fault, 1'b1);
      chk("halt_req_a", a_mem_req, 1'b0);
      chk("halt_req_b", b_mem_req, 1'b0);
      chk("halt_pc_a", a_pc, pc_a);
      mem_ready = 1'b1; exec_done = 1'b1;
      @(negedge clk);
    end

    do_reset("reset1");
    run_instr(3, 0, 3, 1'b0, 32'h0, 1'b1, 32'h44, 32'hA5A5A5A5);
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset asserted in the middle of a STORE access.
    check_bus("pre_store_fetch", 1'b1, 1'b0, pc_a, pc_b, 32'h0, 1'b0);
    mem_ready = 1'b1; exec_done = 1'b0;
    @(negedge clk);
    exec_done = 1'b1; store_req = 1'b1; store_addr = 32'h40; store_data = 32'hDEADBEEF;
    branch_taken = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_bus("abort_store", 1'b1, 1'b1, 32'h40, 8'h40, 32'hDEADBEEF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    do_reset("reset2");
    run_instr(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("post_reset_count", a_instr_count, 32'd1);
    chk("post_reset_pc", a_pc, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
